// File: rtl/banzai_chip_arbiter.sv
// Round-robin arbiter sharing the chip command port between the power sequencer (0)
// and the host controller (1); one command in flight, completion under a timeout.
module banzai_chip_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [3:0]          req_op,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                chip_cmd_valid,
  input  logic                chip_cmd_ready,
  output logic [1:0]          chip_cmd_op,
  output logic [ADDR_W-1:0]   chip_cmd_addr,
  output logic [DATA_W-1:0]   chip_cmd_wdata,
  input  logic                chip_done,
  input  logic [DATA_W-1:0]   chip_rdata,
  output logic                busy,
  output logic                grant_id
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [1:0] OP_RSVD = 2'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic                last_grant;
  logic                sel;
  logic                accept;
  logic                timeout;
  logic                rsp_hs;
  logic [1:0]          op_sel;
  logic [ADDR_W-1:0]   addr_sel;
  logic [DATA_W-1:0]   wdata_sel;
  logic [CNT_W-1:0]    cnt;

  // On a tie the requester that was not served last wins.
  assign sel       = req_valid[1] & (~req_valid[0] | ~last_grant);
  assign op_sel    = sel ? req_op[3:2] : req_op[1:0];
  assign addr_sel  = sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
  assign wdata_sel = sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    req_ready      = 2'b00;
    rsp_valid      = 2'b00;
    chip_cmd_valid = 1'b0;
    accept         = 1'b0;
    timeout        = 1'b0;
    rsp_hs         = 1'b0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (req_valid != 2'b00) begin
          accept    = 1'b1;
          req_ready = sel ? 2'b10 : 2'b01;
          state_nxt = (op_sel == OP_RSVD) ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        chip_cmd_valid = 1'b1;
        if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end else if (chip_cmd_ready) begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A completion landing on the final counted cycle still counts as success.
        if (chip_done) begin
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = grant_id ? 2'b10 : 2'b01;
        if (rsp_ready[grant_id]) begin
          rsp_hs    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant     <= 1'b1;
      grant_id       <= 1'b0;
      cnt            <= '0;
      chip_cmd_op    <= '0;
      chip_cmd_addr  <= '0;
      chip_cmd_wdata <= '0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
    end else begin
      if (accept) begin
        grant_id       <= sel;
        chip_cmd_op    <= op_sel;
        chip_cmd_addr  <= addr_sel;
        chip_cmd_wdata <= wdata_sel;
        cnt            <= '0;
        if (op_sel == OP_RSVD) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
      // Counter leaves ISSUE/WAIT no later than TIMEOUT, so it cannot wrap.
      if (state == ISSUE || state == WAIT) cnt <= cnt + 1'b1;
      if (timeout) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end else if (state == WAIT && chip_done) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= chip_rdata;
      end
      if (rsp_hs) last_grant <= grant_id;
    end
  end

endmodule

// File: tb/tb_banzai_chip_arbiter.sv
// Bench for banzai_chip_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the arbiter.
module tb_banzai_chip_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO    = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]        req_op;
  logic [15:0]       req_addr;
  logic [63:0]       req_wdata;
  logic [31:0]       rsp_rdata, chip_cmd_wdata, chip_rdata;
  logic              rsp_err, chip_cmd_valid, chip_cmd_ready, chip_done, busy, grant_id;
  logic [1:0]        chip_cmd_op;
  logic [7:0]        chip_cmd_addr;

  int errs = 0;
  int checks = 0;

  // Model: one outstanding transaction record plus arbitration memory.
  bit          m_act, m_sent, m_rsp, m_g, m_last, m_err;
  logic [1:0]  m_op;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  int          m_age;

  always #5 clk = ~clk;

  banzai_chip_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .chip_cmd_valid(chip_cmd_valid), .chip_cmd_ready(chip_cmd_ready),
    .chip_cmd_op(chip_cmd_op), .chip_cmd_addr(chip_cmd_addr), .chip_cmd_wdata(chip_cmd_wdata),
    .chip_done(chip_done), .chip_rdata(chip_rdata),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic bit m_sel();
    return (req_valid == 2'b11) ? !m_last : req_valid[1];
  endfunction

  task automatic model_reset();
    m_act = 0; m_sent = 0; m_rsp = 0; m_g = 0; m_last = 1; m_err = 0;
    m_op = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_age = 0;
  endtask

  task automatic post(input bit err, input logic [31:0] d);
    m_rsp = 1; m_err = err; m_rdata = d;
  endtask

  task automatic check();
    logic [1:0] er;
    bit cv;
    #1;
    er = 2'b00;
    if (!m_act && req_valid != 2'b00) er = m_sel() ? 2'b10 : 2'b01;
    cv = m_act && !m_sent && !m_rsp;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("busy", 64'(busy), 64'(m_act));
    chk("grant_id", 64'(grant_id), 64'(m_g));
    chk("chip_cmd_valid", 64'(chip_cmd_valid), 64'(cv));
    if (cv) begin
      chk("chip_cmd_op", 64'(chip_cmd_op), 64'(m_op));
      chk("chip_cmd_addr", 64'(chip_cmd_addr), 64'(m_addr));
      chk("chip_cmd_wdata", 64'(chip_cmd_wdata), 64'(m_wdata));
    end
    chk("rsp_valid", 64'(rsp_valid), m_rsp ? (m_g ? 64'd2 : 64'd1) : 64'd0);
    if (m_rsp) begin
      chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
      chk("rsp_err", 64'(rsp_err), 64'(m_err));
    end
  endtask

  task automatic tick();
    bit s;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (!m_act) begin
      if (req_valid != 2'b00) begin
        s = m_sel();
        m_act = 1; m_g = s; m_sent = 0; m_rsp = 0; m_age = 0;
        m_op    = s ? req_op[3:2] : req_op[1:0];
        m_addr  = s ? req_addr[15:8] : req_addr[7:0];
        m_wdata = s ? req_wdata[63:32] : req_wdata[31:0];
        if (m_op == 2'd3) post(1, 32'h0);
      end
    end else if (!m_rsp) begin
      if (!m_sent) begin
        if (m_age == TMO - 1) post(1, 32'h0);
        else if (chip_cmd_ready) m_sent = 1;
      end else begin
        if (chip_done) post(0, chip_rdata);
        else if (m_age == TMO - 1) post(1, 32'h0);
      end
      m_age++;
    end else if (rsp_ready[m_g]) begin
      m_act = 0; m_rsp = 0; m_last = m_g;
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0;
    rsp_ready = 0; chip_cmd_ready = 0; chip_done = 0; chip_rdata = 0;
  endtask

  task automatic finish_cmd();
    int n;
    n = 0;
    req_valid = 0; chip_cmd_ready = 1; chip_done = 1; rsp_ready = 2'b11;
    while (busy && n < 50) begin check(); tick(); n++; end
    chk("finish_bound", 64'(busy), 64'd0);
    chip_cmd_ready = 0; chip_done = 0; rsp_ready = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_cmd_valid"}, 64'(chip_cmd_valid), 64'd0);
    chk({tag, "_cmd_op"}, 64'(chip_cmd_op), 64'd0);
    chk({tag, "_cmd_addr"}, 64'(chip_cmd_addr), 64'd0);
    chk({tag, "_cmd_wdata"}, 64'(chip_cmd_wdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_grant_id"}, 64'(grant_id), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    int p_rdy, p_done;
    clear_inputs();
    rst_n = 0;
    model_reset();
    tick(); tick();
    #1;
    chk_all_zero("reset");
    rst_n = 1;
    tick();

    // Single READ from requester 1, minimum latency.
    req_valid = 2'b10; req_op = 4'b0000; req_addr = 16'h1200;
    check(); chk("rd_accept", 64'(req_ready), 64'd2);
    tick();
    req_valid = 0; chip_cmd_ready = 1;
    check(); chk("rd_cmd_valid", 64'(chip_cmd_valid), 64'd1);
    chk("rd_cmd_addr", 64'(chip_cmd_addr), 64'h12);
    tick();
    chip_cmd_ready = 0; chip_done = 1; chip_rdata = 32'hDEADBEEF;
    check(); tick();
    chip_done = 0;
    check();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd2);
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    rsp_ready = 2'b10; tick(); rsp_ready = 0;
    check(); chk("rd_idle", 64'(busy), 64'd0);
    tick();

    // Timeout: chip never completes.
    req_valid = 2'b01; req_op = 4'b0000; req_addr = 16'h0034;
    check(); tick();
    req_valid = 0; n = 0;
    while (rsp_valid == 2'b00 && n < 40) begin
      chip_cmd_ready = (n == 0);
      check(); tick(); n++;
    end
    chip_cmd_ready = 0;
    chk("tmo_cycles", 64'(n), 64'd16);
    check();
    chk("tmo_err", 64'(rsp_err), 64'd1);
    chk("tmo_rdata", 64'(rsp_rdata), 64'd0);
    chk("tmo_cmd_valid", 64'(chip_cmd_valid), 64'd0);
    rsp_ready = 2'b01; tick(); rsp_ready = 0;

    // chip_done on the last counted cycle beats the timeout.
    req_valid = 2'b01; req_op = 4'b0000; req_addr = 16'h0077;
    check(); tick();
    req_valid = 0; n = 0; chip_rdata = 32'hCAFEF00D;
    while (rsp_valid == 2'b00 && n < 40) begin
      chip_cmd_ready = (n == 0); chip_done = (n == 15);
      check(); tick(); n++;
    end
    chip_cmd_ready = 0; chip_done = 0;
    chk("late_done_cycles", 64'(n), 64'd16);
    check();
    chk("late_done_err", 64'(rsp_err), 64'd0);
    chk("late_done_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
    rsp_ready = 2'b01; tick(); rsp_ready = 0;

    // Command stall then response stall with the other requester waiting.
    req_valid = 2'b01; req_op = 4'b0001; req_addr = 16'h0056; req_wdata = 64'h12345678;
    check(); tick();
    req_valid = 0; req_wdata = 0; req_addr = 0;
    for (int i = 0; i < 5; i++) begin
      check();
      chk("stall_cmd_valid", 64'(chip_cmd_valid), 64'd1);
      chk("stall_wdata", 64'(chip_cmd_wdata), 64'h12345678);
      chk("stall_addr", 64'(chip_cmd_addr), 64'h56);
      tick();
    end
    chip_cmd_ready = 1; check(); tick(); chip_cmd_ready = 0;
    chip_done = 1; chip_rdata = 32'h0000A5A5; check(); tick(); chip_done = 0;
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      check();
      chk("rsp_hold_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_hold_rdata", 64'(rsp_rdata), 64'hA5A5);
      chk("rsp_hold_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 2'b01; check(); tick(); rsp_ready = 0;
    check(); chk("after_rsp_accept", 64'(req_ready), 64'd2);
    tick();
    finish_cmd();

    // Reserved op answers immediately without touching the chip.
    req_valid = 2'b01; req_op = 4'b0011; req_addr = 16'h0099;
    check(); tick();
    req_valid = 0; req_op = 0;
    check();
    chk("rsvd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsvd_err", 64'(rsp_err), 64'd1);
    chk("rsvd_rdata", 64'(rsp_rdata), 64'd0);
    chk("rsvd_cmd_valid", 64'(chip_cmd_valid), 64'd0);
    rsp_ready = 2'b01; tick(); rsp_ready = 0;

    // Reset while waiting on the chip.
    req_valid = 2'b01; req_op = 4'b0000; req_addr = 16'h0042;
    check(); tick();
    req_valid = 0; chip_cmd_ready = 1; check(); tick(); chip_cmd_ready = 0;
    check(); tick();
    rst_n = 0;
    #1;
    chk_all_zero("midreset");
    model_reset();
    tick();
    rst_n = 1;
    req_valid = 2'b10; req_op = 4'b0000; req_addr = 16'h1100; chip_rdata = 32'h0BADF00D;
    check(); chk("post_reset_accept", 64'(req_ready), 64'd2);
    tick();
    finish_cmd();

    // Both requesters held: grants must alternate starting with 0.
    req_valid = 2'b11; req_op = 4'b0101; chip_cmd_ready = 1; chip_done = 1; rsp_ready = 2'b11;
    k = 0;
    for (int c = 0; c < 200 && k < 8; c++) begin
      check();
      if (req_ready != 2'b00) begin
        chk("rr_grant", 64'(req_ready[1]), 64'(k % 2));
        k++;
      end
      tick();
    end
    chk("rr_count", 64'(k), 64'd8);
    finish_cmd();

    // Randomized traffic in three chip-behaviour regimes.
    for (int seg = 0; seg < 3; seg++) begin
      p_rdy  = (seg == 0) ? 70 : (seg == 1) ? 50 : 90;
      p_done = (seg == 0) ? 40 : (seg == 1) ? 3 : 90;
      for (int i = 0; i < 1000; i++) begin
        req_valid      = 2'($urandom_range(0, 3));
        req_op         = 4'($urandom);
        req_addr       = 16'($urandom);
        req_wdata      = {$urandom, $urandom};
        rsp_ready      = 2'($urandom_range(0, 3));
        chip_cmd_ready = ($urandom_range(0, 99) < p_rdy);
        chip_done      = ($urandom_range(0, 99) < p_done);
        chip_rdata     = $urandom;
        check(); tick();
      end
    end
    finish_cmd();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
